seq_int_divider: RTL and testbench

- Iterative unsigned integer divider for the TABLA FPGA datapath. Computes out = in1 / in2 (quotient, truncated) using a restoring shift-subtract algorithm, one quotient bit per clock.
- Used wherever a PE or the host-side logic needs an occasional divide and can tolerate multi-cycle latency.
- Completion is signalled with a one-cycle done pulse.

---
 rtl/divider_pkg.sv | 19 +
 rtl/div_step.sv | 26 ++
 rtl/seq_int_divider.sv | 129 ++++++++++++
 tb/tb_seq_int_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DATA_LEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must hold DATA_LEN itself, hence one bit beyond clog2.
    function automatic int unsigned cnt_width(input int unsigned data_len);
        return $clog2(data_len) + 1;
    endfunction

    localparam int unsigned CNT_W_DEF = $clog2(DATA_LEN_DEF) + 1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and
// subtracts the divisor when it fits, producing one quotient bit.
module div_step #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] i_rem,
    input  logic                i_msb,
    input  logic [DATA_LEN-1:0] i_divisor,
    output logic [DATA_LEN-1:0] o_rem,
    output logic                o_qbit
);

    logic [DATA_LEN:0] w_shifted;
    logic [DATA_LEN:0] w_divisor_ext;

    // Full-width shift keeps the remainder MSB, so large divisors never overflow.
    assign w_shifted     = {i_rem, i_msb};
    assign w_divisor_ext = {1'b0, i_divisor};

    always_comb begin
        o_qbit = (w_shifted >= w_divisor_ext);
        o_rem  = o_qbit ? DATA_LEN'(w_shifted - w_divisor_ext)
                        : DATA_LEN'(w_shifted);
    end

endmodule

// File: rtl/seq_int_divider.sv
// Iterative unsigned divider: one quotient bit per clock, registered
// quotient and a single-cycle done pulse on completion.
module seq_int_divider
    import divider_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_LEN-1:0] in1,
    input  logic [DATA_LEN-1:0] in2,
    output logic [DATA_LEN-1:0] out,
    output logic                done,
    output logic                busy
);

    localparam int unsigned CNT_W = cnt_width(DATA_LEN);

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_LEN-1:0] r_dividend;
    logic [DATA_LEN-1:0] r_divisor;
    logic [DATA_LEN-1:0] r_rem;
    logic [DATA_LEN-1:0] r_quo;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_LEN-1:0] w_dividend_d;
    logic [DATA_LEN-1:0] w_divisor_d;
    logic [DATA_LEN-1:0] w_rem_d;
    logic [DATA_LEN-1:0] w_quo_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [DATA_LEN-1:0] w_out_d;
    logic                w_done_d;
    logic                w_busy_d;

    logic [DATA_LEN-1:0] w_step_rem;
    logic                w_step_qbit;

    div_step #(
        .DATA_LEN (DATA_LEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_msb     (r_dividend[DATA_LEN-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC:    if (r_cnt == CNT_W'(1)) w_state_next = FINISH;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_dividend_d = r_dividend;
        w_divisor_d  = r_divisor;
        w_rem_d      = r_rem;
        w_quo_d      = r_quo;
        w_cnt_d      = r_cnt;
        w_out_d      = out;
        w_done_d     = 1'b0;
        w_busy_d     = busy;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_dividend_d = in1;
                    w_divisor_d  = in2;
                    w_rem_d      = '0;
                    w_quo_d      = '0;
                    w_cnt_d      = CNT_W'(DATA_LEN);
                    w_busy_d     = 1'b1;
                end
            end
            CALC: begin
                w_dividend_d = {r_dividend[DATA_LEN-2:0], 1'b0};
                w_rem_d      = w_step_rem;
                w_quo_d      = {r_quo[DATA_LEN-2:0], w_step_qbit};
                w_cnt_d      = r_cnt - CNT_W'(1);
            end
            FINISH: begin
                w_out_d  = r_quo;
                w_done_d = 1'b1;
                w_busy_d = 1'b0;
            end
            default: begin
                w_busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; out only moves on FINISH or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            out        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_dividend <= w_dividend_d;
            r_divisor  <= w_divisor_d;
            r_rem      <= w_rem_d;
            r_quo      <= w_quo_d;
            r_cnt      <= w_cnt_d;
            out        <= w_out_d;
            done       <= w_done_d;
            busy       <= w_busy_d;
        end
    end

endmodule

// File: tb/tb_seq_int_divider.sv
// Scoreboard bench for seq_int_divider: directed cases plus random divides
// checked against plain integer division.
module tb_seq_int_divider;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    logic [W-1:0] out;
    logic         done;
    logic         busy;

    seq_int_divider #(.DATA_LEN(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] q;
        int unsigned  acc;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp    = 0;
    int           n_err    = 0;
    logic [W-1:0] last_out = '0;

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
        return a / b;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pop on done, check value and latency; otherwise out must hold.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_out = '0;
        end else if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("quotient", out, e.q);
                check("latency", W'(cyc - e.acc), W'(LAT));
                last_out = e.q;
            end
        end else begin
            check("out_hold", out, last_out);
            if (exp_q.size() != 0) check("busy_high", W'(busy), W'(1));
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("idle_timeout", W'(busy), W'(0));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        e.q   = ref_div(a, b);
        e.acc = cyc;
        exp_q.push_back(e);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("drain_timeout", W'(exp_q.size()), W'(0));
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   k;
        logic [W-1:0] a;
        logic [W-1:0] b;

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", out, '0);
        check("rst_done", W'(done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        reset = 1'b0;

        issue(32'd2, 32'd2);
        drain();

        issue(32'd10, 32'd4);
        issue(32'd10, 32'd3);
        drain();

        issue(32'hFFFF_FFFF, 32'd1);
        issue(32'd5, 32'd7);
        issue(32'd123, 32'd0);
        issue(32'd0, 32'd9);
        drain();

        // start held high while busy with inputs changing underneath
        wait_idle();
        start = 1'b1;
        in1   = 32'd100;
        in2   = 32'd10;
        @(posedge clk);
        #1;
        e.q   = 32'd10;
        e.acc = cyc;
        exp_q.push_back(e);
        in1 = 32'd9;
        in2 = 32'd3;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("held_done_timeout", W'(done), W'(1));
        @(posedge clk);
        #1;
        e.q   = 32'd3;
        e.acc = cyc;
        exp_q.push_back(e);
        start = 1'b0;
        drain();

        // abort mid-calculation; no done may follow
        wait_idle();
        start = 1'b1;
        in1   = 32'd100;
        in2   = 32'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out", out, '0);
        check("abort_done", W'(done), W'(0));
        check("abort_busy", W'(busy), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd100, 32'd10);
        drain();

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = a >> $urandom_range(0, 16);
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = a;
                default: b = W'($urandom) >> $urandom_range(0, 31);
            endcase
            issue(a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
